// File: rtl/servo_motion_sequencer.sv
// rtl/servo_motion_sequencer.sv - per-channel servo position ramping with frame-synchronous sweep
module servo_motion_sequencer #(
    parameter int N_CH       = 4,
    parameter int FRAME_CLKS = 1000000,
    parameter int POS_MAX    = 50000,
    parameter int PARK       = 25000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_ch,
    input  logic [15:0]         cmd_pos,
    input  logic [15:0]         cmd_step,
    output logic [32*N_CH-1:0]  control,
    output logic [N_CH-1:0]     busy,
    output logic                frame_tick
);

    localparam logic [19:0] FRAME_LAST = 20'(FRAME_CLKS - 1);
    localparam logic [15:0] POS_MAX16  = 16'(POS_MAX);
    localparam logic [15:0] PARK16     = 16'(PARK);
    localparam logic [3:0]  LAST_IDX   = 4'(N_CH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t      state_q, state_n;
    logic [3:0]  idx_q, idx_n;
    logic [19:0] frame_cnt_q;

    logic [15:0] pos_q  [N_CH];
    logic [15:0] tgt_q  [N_CH];
    logic [15:0] step_q [N_CH];
    logic [15:0] pos_n  [N_CH];
    logic [15:0] tgt_n  [N_CH];
    logic [15:0] step_n [N_CH];

    logic        cmd_fire;
    logic        ch_ok;
    logic [15:0] cmd_clamped;

    // One step of position toward target; 17-bit sums so the ramp never wraps.
    function automatic logic [15:0] step_toward(input logic [15:0] p,
                                                input logic [15:0] t,
                                                input logic [15:0] s);
        logic [16:0] up;
        logic [16:0] lim;
        up  = {1'b0, p} + {1'b0, s};
        lim = {1'b0, t} + {1'b0, s};
        if (s == 16'd0 || p == t)
            return p;
        else if (p < t)
            return (up >= {1'b0, t}) ? t : up[15:0];
        else
            return ({1'b0, p} <= lim) ? t : (p - s);
    endfunction

    assign frame_tick  = (frame_cnt_q == FRAME_LAST);
    assign cmd_ready   = (state_q == IDLE) && !reset;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign ch_ok       = ({1'b0, cmd_ch} < 5'(N_CH));
    assign cmd_clamped = (cmd_pos > POS_MAX16) ? POS_MAX16 : cmd_pos;

    // Free-running frame counter, wraps on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset || frame_tick)
            frame_cnt_q <= 20'd0;
        else
            frame_cnt_q <= frame_cnt_q + 20'd1;
    end

    // FSM state and sweep index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
        end
    end

    // Next-state: start a sweep after each tick, walk every channel once.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_n = SWEEP;
                    idx_n   = 4'd0;
                end
            end
            SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_n = IDLE;
                    idx_n   = 4'd0;
                end else begin
                    idx_n = idx_q + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Channel datapath: commands only land in IDLE, sweep steps only in SWEEP.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pos_n[i]  = pos_q[i];
            tgt_n[i]  = tgt_q[i];
            step_n[i] = step_q[i];
            if (cmd_fire && ch_ok && cmd_ch == 4'(i)) begin
                tgt_n[i]  = cmd_clamped;
                step_n[i] = cmd_step;
                if (cmd_step == 16'd0)
                    pos_n[i] = cmd_clamped;
            end
            if (state_q == SWEEP && idx_q == 4'(i))
                pos_n[i] = step_toward(pos_q[i], tgt_q[i], step_q[i]);
        end
    end

    // Channel registers and busy flags, busy follows the post-update relation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                pos_q[i]  <= PARK16;
                tgt_q[i]  <= PARK16;
                step_q[i] <= 16'd0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                pos_q[i]  <= pos_n[i];
                tgt_q[i]  <= tgt_n[i];
                step_q[i] <= step_n[i];
                busy[i]   <= (pos_n[i] != tgt_n[i]);
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ctrl
        assign control[32*g +: 32] = {16'b0, pos_q[g]};
    end

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// tb/tb_servo_motion_sequencer.sv - directed self-checking bench for servo_motion_sequencer
module tb_servo_motion_sequencer;

    localparam int N_CH = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [3:0]         cmd_ch;
    logic [15:0]        cmd_pos;
    logic [15:0]        cmd_step;
    logic [32*N_CH-1:0] control;
    logic [N_CH-1:0]    busy;
    logic               frame_tick;

    int checks   = 0;
    int failures = 0;

    servo_motion_sequencer #(
        .N_CH(N_CH), .FRAME_CLKS(100), .POS_MAX(50000), .PARK(25000)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .cmd_step(cmd_step),
        .control(control), .busy(busy), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return control[32*i +: 32];
    endfunction

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 300);
        check("tick_seen", {31'b0, frame_tick}, 32'd1);
    endtask

    task automatic send(input logic [3:0] ch, input logic [15:0] p, input logic [15:0] s,
                        output int waits);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_pos   = p;
        cmd_step  = s;
        waits     = 0;
        while (!cmd_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    int n;
    int w;
    logic [31:0] ramp_exp [4];
    logic [31:0] ramp_busy [4];

    initial begin
        ramp_exp  = '{32'd25300, 32'd25600, 32'd25900, 32'd26000};
        ramp_busy = '{32'd1, 32'd1, 32'd1, 32'd0};
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_ch    = 4'd0;
        cmd_pos   = 16'd0;
        cmd_step  = 16'd0;
        repeat (3) @(negedge clk);
        check("ready_in_reset", {31'b0, cmd_ready}, 32'd0);

        // Reset release
        reset = 1'b0;
        #1;
        for (int i = 0; i < N_CH; i++) check("reset_word", word(i), 32'd25000);
        check("reset_busy", {28'b0, busy}, 32'd0);
        check("reset_ready", {31'b0, cmd_ready}, 32'd1);
        check("reset_tick", {31'b0, frame_tick}, 32'd0);
        wait_tick(n);
        check("first_tick_cycle", n, 32'd99);
        repeat (5) @(negedge clk);

        // Jump
        send(4'd2, 16'd40000, 16'd0, w);
        check("jump_word2", word(2), 32'd40000);
        check("jump_busy2", {31'b0, busy[2]}, 32'd0);
        check("jump_word0", word(0), 32'd25000);
        check("jump_word3", word(3), 32'd25000);

        // Ramp up
        send(4'd0, 16'd26000, 16'd300, w);
        check("ramp_set_word0", word(0), 32'd25000);
        check("ramp_set_busy0", {31'b0, busy[0]}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            repeat (2) @(negedge clk);
            check("ramp_word0", word(0), ramp_exp[k]);
            check("ramp_busy0", {31'b0, busy[0]}, ramp_busy[k]);
        end

        // Clamp and bad channel
        send(4'd1, 16'd60000, 16'd0, w);
        check("clamp_word1", word(1), 32'd50000);
        send(4'd7, 16'd1000, 16'd0, w);
        check("badch_waits", w, 32'd0);
        check("badch_word0", word(0), 32'd26000);
        check("badch_word1", word(1), 32'd50000);
        check("badch_word2", word(2), 32'd40000);
        check("badch_word3", word(3), 32'd25000);
        check("badch_busy", {28'b0, busy}, 32'd0);

        // Backpressure during sweep
        wait_tick(n);
        @(negedge clk);
        send(4'd3, 16'd25500, 16'd100, w);
        check("bp_waits", w, 32'd4);
        check("bp_word3", word(3), 32'd25000);
        check("bp_busy3", {31'b0, busy[3]}, 32'd1);

        // Command in the tick cycle is used by that frame's sweep
        wait_tick(n);
        send(4'd3, 16'd24000, 16'd700, w);
        check("coll_waits", w, 32'd0);
        repeat (4) @(negedge clk);
        check("coll_word3", word(3), 32'd24300);
        check("coll_busy3", {31'b0, busy[3]}, 32'd1);
        check("coll_ready", {31'b0, cmd_ready}, 32'd1);

        // Reset mid-ramp at sweep idx 2
        send(4'd3, 16'd20000, 16'd1000, w);
        wait_tick(n);
        repeat (3) @(negedge clk);
        check("mid_word3", word(3), 32'd24300);
        check("mid_ready", {31'b0, cmd_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < N_CH; i++) check("rst_mid_word", word(i), 32'd25000);
        check("rst_mid_busy", {28'b0, busy}, 32'd0);
        check("rst_mid_ready", {31'b0, cmd_ready}, 32'd1);
        wait_tick(n);
        check("rst_mid_tick_cycle", n, 32'd99);
        repeat (5) @(negedge clk);
        check("rst_mid_after_word3", word(3), 32'd25000);
        check("rst_mid_after_busy", {28'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_motion_sequencer.md
# servo_motion_sequencer

Multi-channel servo position sequencer that sits between the command/host logic and a bank of servo PWM generators. It holds a target angle and slew rate per channel, and steps each channel's commanded position toward its target once per 20 ms servo frame. It also drives the 32-bit `control` word of every downstream PWM instance, where 0 means 1 ms and POS_MAX means 2 ms. Commands enter through a valid/ready port. Frame-synchronous updates happen in a short sequential sweep.

## Interface
- `N_CH`, 4: number of servo channels (1..16).
- `FRAME_CLKS`, 1000000: clocks per servo frame (20 ms at 50 MHz).
- `POS_MAX`, 50000: maximum position code (2 ms pulse).
- `PARK`, 25000: reset position and reset target for every channel (≤ POS_MAX).

Ports:
- `clk`  in  1  system clock, 50 MHz; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  sequencer can accept a command this cycle.
- `cmd_ch`  in  4  target channel index.
- `cmd_pos`  in  16  target position code.
- `cmd_step`  in  16  maximum change per frame; 0 = jump immediately.
- `control`  out  32*N_CH  flat bus; word i = bits [32i+31:32i] = {16'b0, pos[i]}; feeds PWM instance i.
- `busy`  out  N_CH  bit i = 1 while pos[i] ≠ target[i].
- `frame_tick`  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Per-channel registers: pos[i] (16b), target[i] (16b), step[i] (16b).
- Frame counter (20b) counts 0..FRAME_CLKS-1, then wraps to 0. `frame_tick` = 1 when counter == FRAME_CLKS-1.
- FSM states:
  - IDLE: `cmd_ready` = 1. Goes to SWEEP with idx = 0 on the cycle after `frame_tick`.
  - SWEEP: `cmd_ready` = 0. Updates channel idx, then idx += 1. Returns to IDLE after idx = N_CH-1.
- Command accept rule: `cmd_valid && cmd_ready` on a rising edge.
  - cmd_ch ≥ N_CH: command is consumed and has no effect.
  - Otherwise target[ch] ← min(cmd_pos, POS_MAX) and step[ch] ← cmd_step.
  - If cmd_step == 0, pos[ch] also ← the clamped target on the same edge.
- Sweep update for channel i, computed at 17-bit width so it never overflows:
  - pos < target: pos ← min(pos + step, target).
  - pos > target: pos ← max(pos − step, target).
  - Equal, or step == 0: no change.
- A new command overwrites target and step in place. The ramp continues from the current pos; it never restarts from an old position.
- `busy` is registered and recomputed from pos/target every cycle.
- Reset values:
  - pos[i] = target[i] = PARK; step[i] = 0.
  - `control` words = PARK; `busy` = 0; `frame_tick` = 0.
  - `cmd_ready` = 0 while reset is high, 1 on the first cycle after.
  - Frame counter = 0; FSM = IDLE.
- Reset mid-sweep: abandons the sweep. All channels return to PARK and the partial update is discarded.

## Timing
- Let tick occur in cycle t.
  - `frame_tick` is high in cycle t.
  - SWEEP occupies cycles t+1 .. t+N_CH.
  - Channel i is written at the end of cycle t+1+i; its new `control` word is visible in cycle t+2+i.
  - `cmd_ready` is low in cycles t+1 .. t+N_CH and high again in cycle t+N_CH+1.
- Command accepted in cycle t (same cycle as tick, while still IDLE): it is taken, and the following sweep uses the new target/step.
- Jump command accepted in cycle c: `control` changes in cycle c+1. `busy` reflects the new relation in cycle c+1 (jump) or c+1 (ramp target set).
- `control` is updated only by reset, jump commands and sweep steps. It is stable at all other times.
- No combinational path from `cmd_valid` to `cmd_ready`.

## Test plan
- Reset release (FRAME_CLKS=100, N_CH=4): every `control` word = 25000, `busy` = 0, `cmd_ready` = 1 one cycle after reset deasserts, first `frame_tick` at cycle 99.
- Jump: cmd ch=2, pos=40000, step=0 → word 2 = 40000 next cycle, `busy`[2] stays 0, other words unchanged.
- Ramp up: cmd ch=0, pos=26000, step=300 → after successive sweeps word 0 = 25300, 25600, 25900, 26000; `busy`[0] drops after the 26000 sweep; no overshoot.
- Clamp and bad channel: cmd ch=1, pos=60000, step=0 → word 1 = 50000. Cmd ch=7 → accepted (`cmd_ready` handshake completes), all outputs unchanged.
- Tick collision and backpressure:
  - `cmd_valid` held during a sweep → `cmd_ready` low for exactly 4 cycles, command taken on the first IDLE cycle.
  - Command issued in the `frame_tick` cycle → already applied by that frame's sweep.
- Reset mid-ramp: assert reset during SWEEP idx=2 with a channel ramping down by 1000 → all words = 25000, FSM in IDLE, next sweep occurs after a full 100-cycle frame.
